// File: rtl/press_pattern_pkg.sv
// Shared types and defaults for the press pattern detector.
// The state encoding is fixed so that debug taps read the same everywhere.
package press_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    REPORT  = 2'b10
  } pp_state_t;

  localparam int DEFAULT_WINDOW_CYCLES = 50000000;
  localparam int DEFAULT_MAX_PRESSES   = 3;

endpackage

// File: rtl/window_timer.sv
// Inter-press window timer: counts enabled cycles and flags the last one.
// It holds at PERIOD-1 rather than wrapping; clr has priority over en.
module window_timer #(
  parameter int PERIOD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = $clog2(PERIOD);
  localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/press_pattern_detector.sv
// Groups debounced press pulses into single/double/... events.
// A group closes on window timeout or as soon as MAX_PRESSES is reached.
module press_pattern_detector
  import press_pattern_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
  parameter int MAX_PRESSES   = DEFAULT_MAX_PRESSES,
  parameter int CNT_W         = $clog2(MAX_PRESSES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             press,
  output logic             evt_valid,
  output logic [CNT_W-1:0] evt_count,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PRESSES);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  pp_state_t        state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic             tmr_clr;
  logic             tmr_en;
  logic             expire;

  assign count_inc = count + ONE_C;

  // The window restarts on every counted press and idles at zero outside a group.
  assign tmr_en  = (state == COLLECT);
  assign tmr_clr = (state != COLLECT) || press;

  window_timer #(
    .PERIOD (WINDOW_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      evt_valid <= 1'b0;
      evt_count <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          evt_valid <= 1'b0;
          evt_count <= '0;
          if (press) begin
            state <= COLLECT;
            count <= ONE_C;
            busy  <= 1'b1;
          end
        end
        COLLECT: begin
          if (press) begin
            if (count_inc == MAX_C) begin
              state     <= REPORT;
              count     <= MAX_C;
              evt_valid <= 1'b1;
              evt_count <= MAX_C;
              busy      <= 1'b0;
            end else begin
              count <= count_inc;
            end
          end else if (expire) begin
            state     <= REPORT;
            evt_valid <= 1'b1;
            evt_count <= count;
            busy      <= 1'b0;
          end
        end
        REPORT: begin
          evt_valid <= 1'b0;
          evt_count <= '0;
          // A press landing on the report cycle opens the next group.
          if (press) begin
            state <= COLLECT;
            count <= ONE_C;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          count     <= '0;
          evt_valid <= 1'b0;
          evt_count <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
